// File: rtl/pic_rw_cmd_sequencer_if.sv
// pic_rw_cmd_sequencer_if: CPU strobe bus plus command/read-select outputs of the PIC front end
// master drives cs_n/wr_n/rd_n/a0/din and observes the command outputs; slave is the sequencer.
interface pic_rw_cmd_sequencer_if;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       a0;
  logic [7:0] din;
  logic [2:0] cw_flag;
  logic [7:0] cw_data;
  logic       cw_strobe;
  logic [2:0] rd_sel;
  logic       dbus_oe;
  logic       init_done;
  logic       poll_pending;
  modport master (
    output cs_n, wr_n, rd_n, a0, din,
    input  cw_flag, cw_data, cw_strobe, rd_sel, dbus_oe, init_done, poll_pending
  );
  modport slave (
    input  cs_n, wr_n, rd_n, a0, din,
    output cw_flag, cw_data, cw_strobe, rd_sel, dbus_oe, init_done, poll_pending
  );
endinterface

// File: rtl/pic_rw_cmd_sequencer.sv
// pic_rw_cmd_sequencer: 8259-style bus front end; syncs CPU strobes, sequences ICW1-4, classifies OCW1-3, selects read source
// Ports: clk, reset (sync, active-high), bus (slave modport: cs_n/wr_n/rd_n/a0/din in;
//   cw_flag/cw_data/cw_strobe command strobe out, rd_sel/dbus_oe read path out, init_done, poll_pending).
// Optional macro PIC_POLL_CMD_EN enables the OCW3 poll command (poll_pending, rd_sel=100).
module pic_rw_cmd_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input logic                        clk,
  input logic                        reset,
  pic_rw_cmd_sequencer_if.slave      bus
);
  typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
  // Packed as {cs_n, wr_n, rd_n, a0, din}; inactive level is strobes high, a0/din low.
  localparam logic [11:0] SYNC_RST = 12'hE00;
  logic [11:0] raw, s;
  logic        s_cs_n, s_wr_n, s_rd_n, s_a0;
  logic [7:0]  s_din;
  state_t      state, init_nxt;
  logic        cap_active, cap_a0;
  logic [7:0]  cap_d;
  logic        ris, sngl, ic4;
  logic        wr_low, commit, abort, rd_act;
  logic        icw1_cmd, ocw3_cmd, poll_cmd;
  logic [2:0]  rd_code;
  assign raw = {bus.cs_n, bus.wr_n, bus.rd_n, bus.a0, bus.din};
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = raw;
    end else begin : g_sync
      logic [11:0] q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < SYNC_STAGES; k++) q[k] <= SYNC_RST;
        end else begin
          q[0] <= raw;
          for (int k = 1; k < SYNC_STAGES; k++) q[k] <= q[k-1];
        end
      end
      assign s = q[SYNC_STAGES-1];
    end
  endgenerate
  assign {s_cs_n, s_wr_n, s_rd_n, s_a0, s_din} = s;
  assign wr_low   = ~s_cs_n & ~s_wr_n;
  // A write finishes when wr_n rises; chip select leaving first throws the capture away.
  assign commit   = cap_active & s_wr_n;
  assign abort    = cap_active & s_cs_n & ~s_wr_n;
  // Writes take priority: any write capture in flight blocks the read path.
  assign rd_act   = ~s_cs_n & ~s_rd_n & ~wr_low & ~cap_active;
  assign icw1_cmd = commit & ~cap_a0 & cap_d[4];
  assign ocw3_cmd = commit & (state == READY) & ~cap_a0 & ~cap_d[4] & cap_d[3];
  always_comb begin
    init_nxt = READY;
    if (state == WAIT_ICW2 && !sngl) init_nxt = WAIT_ICW3;
    else if (state != WAIT_ICW4 && ic4) init_nxt = WAIT_ICW4;
  end
`ifdef PIC_POLL_CMD_EN
  logic poll_q, poll_rd;
  assign poll_cmd         = cap_d[2];
  assign bus.poll_pending = poll_q;
  assign rd_code          = s_a0 ? 3'b011 : poll_q ? 3'b100 : ris ? 3'b101 : 3'b001;
  // poll_rd marks a read that is returning the poll word; its end retires the poll.
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_q  <= 1'b0;
      poll_rd <= 1'b0;
    end else begin
      poll_rd <= rd_act & ((~s_a0 & poll_q) | poll_rd);
      if (icw1_cmd) poll_q <= 1'b0;
      else if (ocw3_cmd && poll_cmd) poll_q <= 1'b1;
      else if (poll_rd && !rd_act) poll_q <= 1'b0;
    end
  end
`else
  assign poll_cmd         = 1'b0;
  assign bus.poll_pending = 1'b0;
  assign rd_code          = s_a0 ? 3'b011 : ris ? 3'b101 : 3'b001;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cap_active    <= 1'b0;
      cap_a0        <= 1'b0;
      cap_d         <= 8'h00;
      ris           <= 1'b0;
      sngl          <= 1'b0;
      ic4           <= 1'b0;
      bus.cw_flag   <= 3'b111;
      bus.cw_data   <= 8'h00;
      bus.cw_strobe <= 1'b0;
      bus.rd_sel    <= 3'b000;
      bus.dbus_oe   <= 1'b0;
      bus.init_done <= 1'b0;
    end else begin
      bus.cw_strobe <= 1'b0;
      bus.cw_flag   <= 3'b111;
      bus.dbus_oe   <= rd_act;
      bus.rd_sel    <= rd_act ? rd_code : 3'b000;
      if (wr_low) begin
        cap_active <= 1'b1;
        cap_a0     <= s_a0;
        cap_d      <= s_din;
      end else if (commit || abort) begin
        cap_active <= 1'b0;
      end
      if (icw1_cmd) begin
        bus.cw_strobe <= 1'b1;
        bus.cw_flag   <= 3'd0;
        bus.cw_data   <= cap_d;
        sngl          <= cap_d[1];
        ic4           <= cap_d[0];
        ris           <= 1'b0;
        state         <= WAIT_ICW2;
        bus.init_done <= 1'b0;
      end else if (commit && state == READY) begin
        bus.cw_strobe <= 1'b1;
        bus.cw_data   <= cap_d;
        bus.cw_flag   <= cap_a0 ? 3'd4 : cap_d[3] ? 3'd6 : 3'd5;
        if (ocw3_cmd && cap_d[1] && !poll_cmd) ris <= cap_d[0];
      end else if (commit && cap_a0 && state != IDLE) begin
        bus.cw_strobe <= 1'b1;
        bus.cw_data   <= cap_d;
        bus.cw_flag   <= state == WAIT_ICW2 ? 3'd1 : state == WAIT_ICW3 ? 3'd2 : 3'd3;
        state         <= init_nxt;
        bus.init_done <= init_nxt == READY;
      end
    end
  end
endmodule

// File: tb/tb_pic_rw_cmd_sequencer.sv
// tb_pic_rw_cmd_sequencer: directed plus random bus cycles checked against a command-level model
module tb_pic_rw_cmd_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [10:0] strobes [$];
  int need_q [$];
  bit m_inited, m_ris, m_poll;
  pic_rw_cmd_sequencer_if bus ();
  pic_rw_cmd_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.cw_strobe === 1'b1) strobes.push_back({bus.cw_flag, bus.cw_data});
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int mdl_write(bit a, logic [7:0] d);
    if (!a && d[4]) begin
      need_q = {1};
      if (!d[1]) need_q.push_back(2);
      if (d[0]) need_q.push_back(3);
      m_inited = 1;
      m_ris = 0;
      m_poll = 0;
      return 0;
    end
    if (!m_inited) return -1;
    if (need_q.size() != 0) return a ? need_q.pop_front() : -1;
    if (a) return 4;
    if (!d[3]) return 5;
`ifdef PIC_POLL_CMD_EN
    if (d[2]) begin
      m_poll = 1;
      return 6;
    end
`endif
    if (d[1]) m_ris = d[0];
    return 6;
  endfunction
  function automatic bit exp_init();
    return m_inited && need_q.size() == 0;
  endfunction
  task automatic settle_checks(string tag);
    chk({tag, "_init_done"}, bus.init_done, exp_init());
    chk({tag, "_idle_flag"}, bus.cw_flag, 3'b111);
    chk({tag, "_poll"}, bus.poll_pending, m_poll);
  endtask
  task automatic do_write(bit a, logic [7:0] d, bit with_rd = 0);
    int f;
    bit bad_rd;
    f = mdl_write(a, d);
    bad_rd = 0;
    strobes.delete();
    @(negedge clk);
    bus.cs_n = 0; bus.a0 = a; bus.din = 8'($urandom); bus.wr_n = 0; bus.rd_n = !with_rd;
    @(negedge clk);
    bus.din = d;
    @(negedge clk);
    bad_rd |= (bus.rd_sel !== 3'b000) || (bus.dbus_oe !== 1'b0);
    bus.wr_n = 1; bus.rd_n = 1;
    @(negedge clk);
    bus.cs_n = 1;
    for (int i = 0; i < 8; i++) begin
      bad_rd |= (bus.rd_sel !== 3'b000) || (bus.dbus_oe !== 1'b0);
      @(negedge clk);
    end
    chk("strobe_count", strobes.size(), f < 0 ? 0 : 1);
    if (f >= 0 && strobes.size() == 1) begin
      chk("cw_flag", strobes[0][10:8], f);
      chk("cw_data", strobes[0][7:0], d);
      chk("cw_data_hold", bus.cw_data, d);
    end
    if (with_rd) chk("rd_wr_sel", bad_rd, 0);
    settle_checks("wr");
  endtask
  task automatic do_read(bit a);
    logic [2:0] code;
    code = a ? 3'b011 : m_poll ? 3'b100 : m_ris ? 3'b101 : 3'b001;
    @(negedge clk);
    bus.cs_n = 0; bus.rd_n = 0; bus.a0 = a;
    repeat (5) @(negedge clk);
    chk("rd_sel", bus.rd_sel, code);
    chk("dbus_oe", bus.dbus_oe, 1);
    chk("rd_poll", bus.poll_pending, m_poll);
    bus.rd_n = 1; bus.cs_n = 1;
    if (!a) m_poll = 0;
    repeat (5) @(negedge clk);
    chk("rd_sel_idle", bus.rd_sel, 3'b000);
    chk("dbus_oe_idle", bus.dbus_oe, 0);
    settle_checks("rd");
  endtask
  task automatic do_abort();
    strobes.delete();
    @(negedge clk);
    bus.cs_n = 0; bus.wr_n = 0; bus.a0 = 1; bus.din = 8'hA5;
    repeat (2) @(negedge clk);
    bus.cs_n = 1;
    repeat (2) @(negedge clk);
    bus.wr_n = 1;
    repeat (8) @(negedge clk);
    chk("abort_strobes", strobes.size(), 0);
    settle_checks("abort");
  endtask
  task automatic do_b2b(logic [7:0] d1, logic [7:0] d2);
    int f1, f2;
    f1 = mdl_write(1, d1);
    f2 = mdl_write(1, d2);
    strobes.delete();
    @(negedge clk);
    bus.cs_n = 0; bus.a0 = 1; bus.din = d1; bus.wr_n = 0;
    repeat (2) @(negedge clk);
    bus.wr_n = 1;
    @(negedge clk);
    bus.din = d2; bus.wr_n = 0;
    repeat (2) @(negedge clk);
    bus.wr_n = 1;
    @(negedge clk);
    bus.cs_n = 1;
    repeat (8) @(negedge clk);
    chk("b2b_count", strobes.size(), 2);
    if (strobes.size() == 2) begin
      chk("b2b_flag0", strobes[0][10:8], f1);
      chk("b2b_data0", strobes[0][7:0], d1);
      chk("b2b_flag1", strobes[1][10:8], f2);
      chk("b2b_data1", strobes[1][7:0], d2);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    need_q.delete();
    m_inited = 0; m_ris = 0; m_poll = 0;
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_cw_flag", bus.cw_flag, 3'b111);
    chk("rst_cw_data", bus.cw_data, 8'h00);
    chk("rst_strobe", bus.cw_strobe, 0);
    chk("rst_rd_sel", bus.rd_sel, 3'b000);
    chk("rst_dbus_oe", bus.dbus_oe, 0);
    chk("rst_poll", bus.poll_pending, 0);
  endtask
  initial begin
    bus.cs_n = 1; bus.wr_n = 1; bus.rd_n = 1; bus.a0 = 0; bus.din = 8'h00;
    do_reset();
    do_write(0, 8'h13); do_write(1, 8'h20); do_write(1, 8'h01);
    do_write(0, 8'h11); do_write(1, 8'h08); do_write(1, 8'h04); do_write(1, 8'h01);
    do_write(1, 8'hFB); do_write(0, 8'h20); do_write(0, 8'h0B);
    do_read(0);
    do_write(0, 8'h0A);
    do_read(0); do_read(1);
    do_reset();
    do_write(1, 8'h55);
    do_write(0, 8'h13); do_write(1, 8'h20); do_write(1, 8'h01);
    do_abort();
    do_write(1, 8'h77, 1);
    do_b2b(8'h3C, 8'hC3);
    do_write(0, 8'h11); do_write(1, 8'h08);
    do_reset();
    do_write(1, 8'h04);
    do_write(0, 8'h13); do_write(1, 8'h20); do_write(1, 8'h01);
    do_write(0, 8'h13);
    do_write(1, 8'h20); do_write(1, 8'h01);
    do_write(0, 8'h0C);
    do_read(0); do_read(0);
    do_write(0, 8'h10 | 8'($urandom_range(0, 3)));
    for (int i = 0; i < 60; i++) begin
      int op;
      logic [7:0] d;
      op = $urandom_range(0, 9);
      d = 8'($urandom);
      if (op == 0) do_write(0, d | 8'h10);
      else if (op <= 4) do_write(1, d);
      else if (op <= 6) do_write(0, d & 8'hEF);
      else do_read(op[0]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
